if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - fetch-stage bus: control inputs, instruction-memory port and IF/ID register outputs
interface if_stage_if;
    logic [1:0]  stall;
    logic        branch_flag;
    logic [31:0] branch_target_addr;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] inst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_adel;

    modport master (
        input  stall, branch_flag, branch_target_addr, flush, new_pc, inst,
        output ce, pc, id_pc, id_inst, id_adel
    );

    modport slave (
        output stall, branch_flag, branch_target_addr, flush, new_pc, inst,
        input  ce, pc, id_pc, id_inst, id_adel
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC sequencing, redirects and IF/ID register
// BRANCH_DELAY_SLOT_EN defined: delay-slot instruction enters IF/ID on a taken branch; undefined: bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    if_stage_if.master    bus
);

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_adel_q, id_adel_d;
    logic        branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            id_pc_q   <= 32'h0;
            id_inst_q <= 32'h0;
            id_adel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            id_adel_q <= id_adel_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        id_pc_d      = id_pc_q;
        id_inst_d    = id_inst_q;
        id_adel_d    = id_adel_q;
        branch_taken = 1'b0;

        case (state_q)
            IDLE: begin
                // Memory is disabled here, so nothing real can be captured.
                state_d   = FETCH;
                pc_d      = RESET_PC;
                id_pc_d   = 32'h0;
                id_inst_d = 32'h0;
                id_adel_d = 1'b0;
            end

            FETCH, HOLD: begin
                state_d      = bus.stall[0] ? HOLD : FETCH;
                branch_taken = bus.branch_flag && !bus.stall[0] && !bus.flush;

                if (bus.flush) begin
                    id_pc_d   = 32'h0;
                    id_inst_d = 32'h0;
                    id_adel_d = 1'b0;
                end else if (bus.stall[1]) begin
                    id_pc_d   = id_pc_q;
                    id_inst_d = id_inst_q;
                    id_adel_d = id_adel_q;
                end else if (bus.stall[0] || (branch_taken && !DELAY_SLOT)) begin
                    id_pc_d   = 32'h0;
                    id_inst_d = 32'h0;
                    id_adel_d = 1'b0;
                end else if (pc_q[1:0] != 2'b00) begin
                    // Misaligned fetch: report the faulting PC, never the fetched word.
                    id_pc_d   = pc_q;
                    id_inst_d = 32'h0;
                    id_adel_d = 1'b1;
                end else begin
                    id_pc_d   = pc_q;
                    id_inst_d = bus.inst;
                    id_adel_d = 1'b0;
                end

                if (bus.flush) begin
                    pc_d = bus.new_pc;
                end else if (bus.stall[0]) begin
                    pc_d = pc_q;
                end else if (bus.branch_flag) begin
                    pc_d = bus.branch_target_addr;
                end else begin
                    pc_d = pc_q + 32'd4;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ce      = (state_q != IDLE);
    assign bus.pc      = pc_q;
    assign bus.id_pc   = id_pc_q;
    assign bus.id_inst = id_inst_q;
    assign bus.id_adel = id_adel_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with a reference fetch model
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    if_stage_if ifc ();

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]} ^ {a[15:0], 16'h0000};
    endfunction

    // Instruction memory: word depends on the address so captures are traceable.
    always_comb ifc.inst = inst_of(ifc.pc);

    int n_asrt = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: machine is "running" once a non-reset edge follows reset.
    bit          m_run;
    logic [31:0] m_pc, m_id_pc, m_id_inst;
    logic        m_id_adel;

    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_pc = RESET_PC;
            m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;
        end else begin
            if (ifc.flush || (!ifc.stall[1] && (ifc.stall[0] ||
                    (ifc.branch_flag && !ifc.stall[0] && !DS)))) begin
                m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;
            end else if (!ifc.stall[1]) begin
                m_id_pc   = m_pc;
                m_id_adel = (m_pc % 4) != 0;
                m_id_inst = m_id_adel ? 32'h0 : inst_of(m_pc);
            end
            if (ifc.flush)            m_pc = ifc.new_pc;
            else if (ifc.stall[0])    m_pc = m_pc;
            else if (ifc.branch_flag) m_pc = ifc.branch_target_addr;
            else                      m_pc = m_pc + 4;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_ce",      {31'h0, ifc.ce},      {31'h0, m_run});
            chk("model_pc",      ifc.pc,               m_pc);
            chk("model_id_pc",   ifc.id_pc,            m_id_pc);
            chk("model_id_inst", ifc.id_inst,          m_id_inst);
            chk("model_id_adel", {31'h0, ifc.id_adel}, {31'h0, m_id_adel});
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1; ifc.stall = 2'b00; ifc.branch_flag = 0; ifc.branch_target_addr = 0;
        ifc.flush = 0; ifc.new_pc = 0;
        cyc(); cyc();
        chk("rst_ce", {31'h0, ifc.ce}, 32'h0);
        chk("rst_pc", ifc.pc, 32'h0);
        chk("rst_id_inst", ifc.id_inst, 32'h0);
        chk_en = 1'b1;

        rst = 0;
        cyc();
        chk("first_ce", {31'h0, ifc.ce}, 32'h1);
        chk("first_pc", ifc.pc, 32'h0);
        cyc();
        chk("seq_id_pc0", ifc.id_pc, 32'h0);
        chk("seq_id_inst0", ifc.id_inst, 32'hC0DE_0000);
        cyc();
        chk("seq_id_pc4", ifc.id_pc, 32'h4);
        chk("seq_id_inst4", ifc.id_inst, 32'hC0DA_0004);
        chk("seq_pc8", ifc.pc, 32'h8);

        ifc.branch_flag = 1; ifc.branch_target_addr = 32'h100;
        cyc();
        chk("br_pc", ifc.pc, 32'h100);
        chk("br_slot_id_pc", ifc.id_pc, DS ? 32'h8 : 32'h0);
        ifc.branch_flag = 0;
        cyc();
        chk("br_tgt_id_pc", ifc.id_pc, 32'h100);

        ifc.flush = 1; ifc.new_pc = 32'hC;
        cyc();
        ifc.flush = 0; ifc.stall = 2'b01;
        cyc(); cyc();
        chk("stall_pc", ifc.pc, 32'hC);
        chk("stall_bubble", ifc.id_inst, 32'h0);
        ifc.stall = 2'b00;
        cyc();
        chk("resume_id_pc", ifc.id_pc, 32'hC);
        chk("resume_id_inst", ifc.id_inst, 32'hC0D2_000C);

        ifc.stall = 2'b11; ifc.flush = 1; ifc.new_pc = 32'h180;
        cyc();
        chk("flush_pc", ifc.pc, 32'h180);
        chk("flush_id_pc", ifc.id_pc, 32'h0);
        ifc.stall = 2'b00; ifc.flush = 0;
        cyc();
        ifc.stall = 2'b10;
        cyc();
        chk("idhold_pc", ifc.pc, 32'h188);
        chk("idhold_id_pc", ifc.id_pc, 32'h180);
        ifc.stall = 2'b00;

        ifc.branch_flag = 1; ifc.branch_target_addr = 32'h102;
        cyc();
        ifc.branch_flag = 0;
        cyc();
        chk("adel_id_pc", ifc.id_pc, 32'h102);
        chk("adel_flag", {31'h0, ifc.id_adel}, 32'h1);
        chk("adel_inst", ifc.id_inst, 32'h0);
        cyc();
        ifc.branch_flag = 1; ifc.branch_target_addr = 32'h200; ifc.stall = 2'b01;
        cyc();
        chk("br_ignored_pc", ifc.pc, 32'h10A);
        ifc.branch_flag = 0; ifc.stall = 2'b00;
        cyc();

        ifc.flush = 1; ifc.new_pc = 32'hFFFF_FFFC;
        cyc();
        ifc.flush = 0;
        cyc();
        chk("wrap_pc", ifc.pc, 32'h0);
        chk("wrap_id_pc", ifc.id_pc, 32'hFFFF_FFFC);
        chk("wrap_id_inst", ifc.id_inst, 32'h3F22_FFFC);

        ifc.stall = 2'b11;
        cyc();
        rst = 1; ifc.branch_flag = 1; ifc.branch_target_addr = 32'h300;
        cyc();
        chk("midrst_ce", {31'h0, ifc.ce}, 32'h0);
        chk("midrst_pc", ifc.pc, 32'h0);
        chk("midrst_id_pc", ifc.id_pc, 32'h0);
        rst = 0; ifc.stall = 2'b00; ifc.branch_flag = 0;
        cyc();
        chk("rerun_ce", {31'h0, ifc.ce}, 32'h1);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
